uart_tx: RTL

Serial transmitter for the team's UART link. It accepts a parallel word through a valid/ready handshake and serialises it onto a single line as one frame: start bit (0), WIDTH data bits LSB first, optional even-parity bit, then stop bit (1). Its output line drives the receive input of the matching receiver. The frame format matches that receiver exactly, so a loopback of the two blocks returns the original word with both error flags low.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_piso.sv | 35 +++
 rtl/uart_tx.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, line levels and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // Even parity over a word zero-extended to 64 bits; extension bits do not change the result.
  function automatic logic even_parity(input logic [63:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/uart_tx_piso.sv
// Parallel-in serial-out shift register, LSB first; counterpart of the receiver's SIPO.
module uart_tx_piso #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             lsb_next
);

  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = din;
    end else if (shift) begin
      q_d = q_q >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  // Exposes the bit the line will carry next so the serial output can be registered.
  assign lsb_next = q_d[0];

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, WIDTH data bits LSB first, optional even parity, stop bit.
// Define UART_TX_PARITY_EN to include the parity bit in every frame.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_valid,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_ready,
  output logic             TX_data,
  output logic             tx_busy,
  output logic             tx_done
);

  localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned CntW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  uart_state_e state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [CntW-1:0]  bit_q, bit_d;
  logic line_q, line_d;
  logic done_q, done_d;
  logic load, shift, bit_end, lsb_next;

  uart_tx_piso #(
    .WIDTH (WIDTH)
  ) u_piso (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .shift    (shift),
    .din      (tx_data),
    .lsb_next (lsb_next)
  );

`ifdef UART_TX_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_q <= 1'b0;
    end else if (load) begin
      parity_q <= even_parity(64'(tx_data));
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    load    = 1'b0;
    shift   = 1'b0;
    bit_end = (baud_q == BaudW'(CLKS_PER_BIT - 1));

    if (state_q != StIdle) begin
      baud_d = bit_end ? '0 : baud_q + BaudW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (tx_valid) begin
          load    = 1'b1;
          state_d = StStart;
          baud_d  = '0;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          bit_d   = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          shift = 1'b1;
          if (bit_q == CntW'(WIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d = bit_q + CntW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (bit_end) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line and done are derived from the next state so both come straight from flops.
  always_comb begin
    line_d = IDLE_LEVEL;
    unique case (state_d)
      StIdle:   line_d = IDLE_LEVEL;
      StStart:  line_d = START_BIT;
      StData:   line_d = lsb_next;
`ifdef UART_TX_PARITY_EN
      StParity: line_d = parity_q;
`endif
      StStop:   line_d = STOP_BIT;
      default:  line_d = IDLE_LEVEL;
    endcase
    done_d = (state_d == StStop) && (baud_d == BaudW'(CLKS_PER_BIT - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      line_q  <= IDLE_LEVEL;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      line_q  <= line_d;
      done_q  <= done_d;
    end
  end

  assign tx_ready = (state_q == StIdle);
  assign tx_busy  = (state_q != StIdle);
  assign TX_data  = line_q;
  assign tx_done  = done_q;

endmodule
